// File: rtl/cmsdk_ahb_ram_ws_pkg.sv
// Shared types and helpers for the wait-state AHB-Lite SRAM slave.
package cmsdk_ahb_ram_ws_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int unsigned WCNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  // Byte-lane mask; big-endian mode mirrors lanes (byte address 0 on bits 31:24).
  function automatic logic [3:0] byte_strb(input logic [2:0] size,
                                           input logic [1:0] addr,
                                           input logic       be);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = 4'b1111;
      default:    m = 4'b0000;
    endcase
    if (be) m = {m[0], m[1], m[2], m[3]};
    return m;
  endfunction

endpackage

// File: rtl/cmsdk_ahb_ram_ws_buf.sv
// One-entry write buffer: holds the last write until it can drain, and forwards its bytes to reads.
module cmsdk_ahb_ram_ws_buf
  import cmsdk_ahb_ram_ws_pkg::*;
#(
  parameter int unsigned IW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [IW-1:0] load_addr,
  input  logic [3:0]    load_strb,
  input  logic          data_last,
  input  logic [31:0]   wdata,
  input  logic          drain_req,
  input  logic [IW-1:0] rd_addr,
  input  logic [31:0]   rd_word,
  output logic          drain_c,
  output logic [IW-1:0] drain_addr_c,
  output logic [3:0]    drain_strb_c,
  output logic [31:0]   drain_data_c,
  output logic [31:0]   merged_c
);

  logic          valid_q;
  logic          pending_q;
  logic [IW-1:0] addr_q;
  logic [3:0]    strb_q;
  logic [31:0]  data_q;
  logic [31:0]  cur_data_c;
  logic          hit_c;

  // While the data phase is still open the live bus data is the buffer content.
  assign cur_data_c   = pending_q ? wdata : data_q;
  assign drain_c      = valid_q && (!pending_q || data_last) && drain_req;
  assign drain_addr_c = addr_q;
  assign drain_strb_c = strb_q;
  assign drain_data_c = cur_data_c;
  assign hit_c        = valid_q && (addr_q == rd_addr);

  always_comb begin
    merged_c = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (hit_c && strb_q[i]) merged_c[8*i +: 8] = cur_data_c[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
    end else begin
      if (pending_q && data_last) begin
        data_q    <= wdata;
        pending_q <= 1'b0;
      end
      if (load) begin
        valid_q   <= 1'b1;
        pending_q <= 1'b1;
        addr_q    <= load_addr;
        strb_q    <= load_strb;
      end else if (drain_c) begin
        valid_q   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmsdk_ahb_ram_ws.sv
// AHB-Lite SRAM slave with NONSEQ/SEQ wait states, write buffer with read forwarding and ERROR responses.
module cmsdk_ahb_ram_ws
  import cmsdk_ahb_ram_ws_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned SIZE_BYTES = 2**AW,
  parameter int unsigned WS_N       = 0,
  parameter int unsigned WS_S       = 0,
  parameter int unsigned BE         = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP
);

  localparam int unsigned IW    = AW - 2;
  localparam int unsigned WORDS = 2**IW;

  if (WS_N > 7 || WS_S > 7) begin : g_ws_check
    $error("cmsdk_ahb_ram_ws: WS_N and WS_S must be in 0..7");
  end

  logic [31:0]       mem [WORDS];

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hrdata_q;

  logic              accept_c;
  logic              err_c;
  logic              wr_ok_c;
  logic              rd_ok_c;
  logic [3:0]        strb_c;
  logic [WCNT_W-1:0] ws_c;
  logic [IW-1:0]     word_c;

  logic              drain_c;
  logic [IW-1:0]     drain_addr_c;
  logic [3:0]        drain_strb_c;
  logic [31:0]       drain_data_c;
  logic [31:0]       merged_c;

  // Address-phase acceptance and legality checks.
  assign accept_c = HSEL && HREADY && HTRANS[1] && hreadyout_q;
  assign err_c    = (HSIZE > HSIZE_WORD)
                 || (HSIZE == HSIZE_HALF && HADDR[0])
                 || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
                 || ((33'(HADDR) + (33'(1) << HSIZE)) > 33'(SIZE_BYTES));
  assign wr_ok_c  = accept_c && HWRITE && !err_c;
  assign rd_ok_c  = accept_c && !HWRITE && !err_c;
  assign strb_c   = byte_strb(HSIZE, HADDR[1:0], BE != 0);
  assign ws_c     = (HTRANS == HTRANS_SEQ) ? WCNT_W'(WS_S) : WCNT_W'(WS_N);
  assign word_c   = HADDR[AW-1:2];

  cmsdk_ahb_ram_ws_buf #(.IW(IW)) u_buf (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .load         (wr_ok_c),
    .load_addr    (word_c),
    .load_strb    (strb_c),
    .data_last    (hreadyout_q),
    .wdata        (HWDATA),
    .drain_req    (!(accept_c && !HWRITE)),
    .rd_addr      (word_c),
    .rd_word      (mem[word_c]),
    .drain_c      (drain_c),
    .drain_addr_c (drain_addr_c),
    .drain_strb_c (drain_strb_c),
    .drain_data_c (drain_data_c),
    .merged_c     (merged_c)
  );

  // Array storage is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (drain_c) begin
      for (int i = 0; i < 4; i++) begin
        if (drain_strb_c[i]) mem[drain_addr_c][8*i +: 8] <= drain_data_c[8*i +: 8];
      end
    end
  end

  // Response FSM; ERR2 is ready, so it accepts a new address phase like IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (err_c) begin
            state_d = ST_ERR1;
          end else if (ws_c != '0) begin
            state_d = ST_WAIT;
            cnt_d   = ws_c;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WCNT_W'(1);
        if (cnt_q <= WCNT_W'(1)) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      // Read data is captured at acceptance and held through the wait states.
      if (rd_ok_c)                hrdata_q <= merged_c;
      else if (state_q != ST_WAIT) hrdata_q <= '0;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_cmsdk_ahb_ram_ws.sv
// Scoreboard bench: little- and big-endian instances share one bus; a monitor checks each data phase.
module tb_cmsdk_ahb_ram_ws;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] S_B = 3'd0;
  localparam logic [2:0] S_H = 3'd1;
  localparam logic [2:0] S_W = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsel = 1'b0;
  logic [15:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic [2:0]  hsize = S_W;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic        hreadyout0, hreadyout1;
  logic [31:0] hrdata0, hrdata1;
  logic        hresp0, hresp1;

  always #5 clk = ~clk;
  assign hready = hreadyout0;

  cmsdk_ahb_ram_ws #(.AW(16), .SIZE_BYTES(32'h8000), .WS_N(2), .WS_S(0), .BE(0)) dut_le (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout0), .HRDATA(hrdata0), .HRESP(hresp0));

  cmsdk_ahb_ram_ws #(.AW(16), .SIZE_BYTES(32'h8000), .WS_N(2), .WS_S(0), .BE(1)) dut_be (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout1), .HRDATA(hrdata1), .HRESP(hresp1));

  typedef struct {
    logic        err;
    int          waits;
    logic        rd;
    logic [31:0] le;
    logic [31:0] be;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pend_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one address phase, hold it until accepted, then queue its expected response.
  task automatic issue(input logic wr, input logic [1:0] trans, input logic [2:0] size,
                       input logic [15:0] addr, input logic [31:0] wd, input logic err,
                       input logic [31:0] le, input logic [31:0] be);
    exp_t e;
    int   n;
    @(negedge clk);
    hsel = 1'b1; htrans = trans; hsize = size; haddr = addr; hwrite = wr; hwdata = pend_wdata;
    n = 0;
    while (!hready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end else begin
      @(posedge clk);
      e.err   = err;
      e.rd    = !wr;
      e.le    = le;
      e.be    = be;
      e.waits = err ? 1 : ((trans == T_SEQ) ? 0 : 2);
      exp_q.push_back(e);
      pend_wdata = wr ? wd : 32'h0;
    end
  endtask

  task automatic idle(input int n, input logic [1:0] trans);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hsel = (trans == T_BUSY); htrans = trans; hwrite = 1'b0; hwdata = pend_wdata;
    end
  endtask

  // Monitor: tracks data phases from observed acceptance and pops the scoreboard on completion.
  logic acc_q;
  logic in_dp = 1'b0;
  int   waits = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= hsel & hready & htrans[1];
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_dp = 1'b0;
      waits = 0;
      exp_q.delete();
    end else begin
      if (acc_q && !in_dp) begin
        in_dp = 1'b1;
        waits = 0;
      end
      if (in_dp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: data phase with no expected entry");
          in_dp = 1'b0;
        end else if (!hreadyout0) begin
          waits++;
          chk("wait_hresp", 32'(hresp0), 32'(exp_q[0].err));
          chk("wait_ready_be", 32'(hreadyout1), 32'(0));
          if (waits > 10) begin
            checks++;
            errors++;
            $display("FAIL wait_overrun: %0d wait cycles", waits);
            void'(exp_q.pop_front());
            in_dp = 1'b0;
          end
        end else begin
          e = exp_q.pop_front();
          chk("waits", 32'(waits), 32'(e.waits));
          chk("hresp", 32'(hresp0), 32'(e.err));
          chk("hresp_be", 32'(hresp1), 32'(e.err));
          chk("ready_be", 32'(hreadyout1), 32'(1));
          chk("hrdata", hrdata0, (e.rd && !e.err) ? e.le : 32'h0);
          chk("hrdata_be", hrdata1, (e.rd && !e.err) ? e.be : 32'h0);
          in_dp = 1'b0;
        end
      end else begin
        chk("idle_ready", 32'(hreadyout0), 32'(1));
        chk("idle_resp", 32'(hresp0 | hresp1), 32'(0));
        chk("idle_rdata", hrdata0 | hrdata1, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(hreadyout0 & hreadyout1), 32'(1));
    chk("rst_resp", 32'(hresp0 | hresp1), 32'(0));
    chk("rst_rdata", hrdata0 | hrdata1, 32'h0);
    rst_n = 1'b1;

    // Preload through the bus.
    issue(1, T_NSEQ, S_W, 16'h0000, 32'hDEADBEEF, 0, 0, 0);
    issue(1, T_SEQ,  S_W, 16'h0004, 32'h01234567, 0, 0, 0);
    issue(1, T_NSEQ, S_W, 16'h7FFC, 32'h0BADF00D, 0, 0, 0);
    issue(1, T_NSEQ, S_W, 16'h0020, 32'h13579BDF, 0, 0, 0);
    idle(4, T_IDLE);

    // NONSEQ then SEQ read: 2 waits then zero-wait.
    issue(0, T_NSEQ, S_W, 16'h0000, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    issue(0, T_SEQ,  S_W, 16'h0004, 0, 0, 32'h01234567, 32'h01234567);

    // Read-after-write forwarding.
    issue(1, T_NSEQ, S_W, 16'h0010, 32'hA5A51234, 0, 0, 0);
    issue(0, T_NSEQ, S_W, 16'h0010, 0, 0, 32'hA5A51234, 32'hA5A51234);
    issue(1, T_SEQ,  S_W, 16'h0014, 32'hCAFEF00D, 0, 0, 0);
    issue(0, T_SEQ,  S_W, 16'h0014, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    // Sub-word writes merged over a word, little vs big endian lanes.
    issue(1, T_NSEQ, S_W, 16'h0010, 32'h11223344, 0, 0, 0);
    issue(1, T_NSEQ, S_B, 16'h0013, 32'hEFEFEFEF, 0, 0, 0);
    issue(0, T_NSEQ, S_W, 16'h0010, 0, 0, 32'hEF223344, 32'h112233EF);
    idle(3, T_IDLE);
    issue(0, T_NSEQ, S_W, 16'h0010, 0, 0, 32'hEF223344, 32'h112233EF);
    issue(1, T_SEQ,  S_H, 16'h0012, 32'hBEEFBEEF, 0, 0, 0);
    issue(0, T_SEQ,  S_W, 16'h0010, 0, 0, 32'hBEEF3344, 32'h1122BEEF);

    // Errors: out of range, misaligned, bad size; errored writes leave the array alone.
    issue(0, T_NSEQ, S_W, 16'h8000, 0, 1, 0, 0);
    issue(0, T_NSEQ, S_H, 16'h0001, 0, 1, 0, 0);
    issue(0, T_NSEQ, 3'd3, 16'h0000, 0, 1, 0, 0);
    issue(1, T_NSEQ, S_W, 16'h8000, 32'h55555555, 1, 0, 0);
    issue(1, T_NSEQ, S_W, 16'h7FFE, 32'hFFFFFFFF, 1, 0, 0);
    issue(0, T_NSEQ, S_W, 16'h7FFC, 0, 0, 32'h0BADF00D, 32'h0BADF00D);
    issue(0, T_NSEQ, S_H, 16'h7FFE, 0, 0, 32'h0BADF00D, 32'h0BADF00D);
    idle(2, T_IDLE);

    // Reset in the middle of a waited write: buffered data must be dropped.
    issue(1, T_NSEQ, S_W, 16'h0020, 32'h2468ACE0, 0, 0, 0);
    @(negedge clk);
    hsel = 1'b0; htrans = T_IDLE; hwdata = 32'h2468ACE0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(hreadyout0 & hreadyout1), 32'(1));
    chk("rst_wait_resp", 32'(hresp0 | hresp1), 32'(0));
    chk("rst_wait_rdata", hrdata0 | hrdata1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend_wdata = 32'h0;
    issue(0, T_NSEQ, S_W, 16'h0020, 0, 0, 32'h13579BDF, 32'h13579BDF);

    // BUSY/IDLE cycles between beats.
    issue(1, T_NSEQ, S_W, 16'h0040, 32'h11110000, 0, 0, 0);
    idle(1, T_BUSY);
    issue(1, T_SEQ,  S_W, 16'h0044, 32'h22220000, 0, 0, 0);
    idle(2, T_IDLE);
    issue(0, T_NSEQ, S_W, 16'h0040, 0, 0, 32'h11110000, 32'h11110000);
    idle(1, T_BUSY);
    issue(0, T_SEQ,  S_W, 16'h0044, 0, 0, 32'h22220000, 32'h22220000);
    idle(4, T_IDLE);

    chk("scoreboard_left", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
